// File: rtl/xor_scheduler_if.sv
// Bundles the requester-side and result-side signals of xor_scheduler.
//   req/in_data/in_valid/in_last : four requesters' request and word stream
//   in_ready/gnt                 : per-requester accept and one-hot grant
//   busy                         : scheduler not idle
//   res_data/res_id/res_valid    : completed XOR checksum and its owner
//   res_ready                    : result accept
//   res_parity                   : reduction XOR of res_data (XOR_SCHEDULER_PARITY_EN only)
// Modports: master = requesters/result consumer, slave = scheduler.
interface xor_scheduler_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_last;
  logic [3:0]         in_ready;
  logic [3:0]         gnt;
  logic               busy;
  logic [WIDTH-1:0]   res_data;
  logic [1:0]         res_id;
  logic               res_valid;
  logic               res_ready;
`ifdef XOR_SCHEDULER_PARITY_EN
  logic               res_parity;
`endif

  modport master (
    output req, in_data, in_valid, in_last, res_ready,
    input  in_ready, gnt, busy, res_data, res_id, res_valid
`ifdef XOR_SCHEDULER_PARITY_EN
    , input res_parity
`endif
  );

  modport slave (
    input  req, in_data, in_valid, in_last, res_ready,
    output in_ready, gnt, busy, res_data, res_id, res_valid
`ifdef XOR_SCHEDULER_PARITY_EN
    , output res_parity
`endif
  );
endinterface

// File: rtl/xor_scheduler.sv
// Round-robin arbiter in front of a single shared XOR accumulator.
// A granted requester streams words until an in_last beat; the XOR of all
// words is presented as res_data/res_id and held until res_ready.
// Ports: clk, rst_n (async active-low), bus (xor_scheduler_if.slave).
// Optional: define XOR_SCHEDULER_PARITY_EN to add bus.res_parity.
module xor_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  xor_scheduler_if.slave bus
);
  localparam int unsigned NREQ = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       gid;
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_data_q;
  logic [1:0]       res_id_q;
  logic             res_valid_q;

  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic [WIDTH-1:0] word;
  logic             beat;
  logic             last_beat;
  logic             res_accept;

  assign bus.gnt       = gnt_q;
  assign bus.in_ready  = gnt_q;  // gnt is zero outside ACCUM
  assign bus.busy      = (state != IDLE);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_valid = res_valid_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration, beat decode and next-state
  always_comb begin
    state_nxt  = state;
    winner     = ptr;
    cand       = ptr;
    found      = 1'b0;
    word       = bus.in_data[gid*WIDTH +: WIDTH];
    beat       = bus.in_valid[gid] & gnt_q[gid];
    last_beat  = beat & bus.in_last[gid];
    res_accept = res_valid_q & bus.res_ready;

    // search ptr+1, ptr+2, ptr+3, ptr (2-bit wrap)
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = ptr + 2'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    case (state)
      IDLE:    if (found)      state_nxt = ACCUM;
      ACCUM:   if (last_beat)  state_nxt = DONE;
      DONE:    if (res_accept) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Grant, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= 2'd3;
      gid         <= 2'd0;
      gnt_q       <= '0;
      acc         <= '0;
      res_data_q  <= '0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q <= 4'b0001 << winner;
            gid   <= winner;
            acc   <= '0;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= acc ^ word;
            if (last_beat) begin
              res_data_q  <= acc ^ word;
              res_id_q    <= gid;
              res_valid_q <= 1'b1;
              gnt_q       <= '0;
              ptr         <= gid;
            end
          end
        end
        DONE: begin
          if (res_accept) res_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef XOR_SCHEDULER_PARITY_EN
  logic res_parity_q;

  // Parity captured alongside res_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          res_parity_q <= 1'b0;
    else if (state == ACCUM && last_beat) res_parity_q <= ^(acc ^ word);
  end

  assign bus.res_parity = res_parity_q;
`endif

endmodule

// File: tb/tb_xor_scheduler.sv
// Directed bench for xor_scheduler: reset values, single/multi-word
// transactions, round-robin order, stalls, result backpressure, mid-transaction reset.
module tb_xor_scheduler;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  xor_scheduler_if #(.WIDTH(WIDTH)) bus ();

  xor_scheduler #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req       = 4'b0000;
    bus.in_data   = '0;
    bus.in_valid  = 4'b0000;
    bus.in_last   = 4'b0000;
    bus.res_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),       32'h0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'h0);
    check({tag, "_busy"},      32'(bus.busy),      32'h0);
    check({tag, "_res_data"},  32'(bus.res_data),  32'h0);
    check({tag, "_res_id"},    32'(bus.res_id),    32'h0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();

    // Reset state
    #2;
    check_all_zero("reset");
`ifdef XOR_SCHEDULER_PARITY_EN
    check("reset_parity", 32'(bus.res_parity), 32'h0);
`endif
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_all_zero("post_release");

    // Two-word transaction from requester 0: A5 ^ 3C = 99
    bus.req = 4'b0001;
    tick();
    check("t1_gnt",      32'(bus.gnt),      32'h1);
    check("t1_in_ready", 32'(bus.in_ready), 32'h1);
    check("t1_busy",     32'(bus.busy),     32'h1);
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_00A5;
    tick();
    check("t1_beat1_no_res", 32'(bus.res_valid), 32'h0);
    bus.in_data = 32'h0000_003C;
    bus.in_last = 4'b0001;
    tick();
    check("t1_res_valid", 32'(bus.res_valid), 32'h1);
    check("t1_res_data",  32'(bus.res_data),  32'h99);
    check("t1_res_id",    32'(bus.res_id),    32'h0);
    check("t1_gnt_done",  32'(bus.gnt),       32'h0);
    idle_inputs();
    bus.res_ready = 1'b1;
    tick();
    check("t1_accept_valid", 32'(bus.res_valid), 32'h0);
    check("t1_accept_busy",  32'(bus.busy),      32'h0);
    bus.res_ready = 1'b0;

    // Round-robin with all four requesting single-word transactions
    do_reset();
    bus.req       = 4'b1111;
    bus.in_valid  = 4'b1111;
    bus.in_last   = 4'b1111;
    bus.in_data   = 32'h0302_0100;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_id;
      exp_id = 2'(i % 4);
      tick();
      check($sformatf("rr%0d_gnt", i), 32'(bus.gnt), 32'(4'b0001 << exp_id));
      tick();
      check($sformatf("rr%0d_res_valid", i), 32'(bus.res_valid), 32'h1);
      check($sformatf("rr%0d_res_id", i),    32'(bus.res_id),    32'(exp_id));
      check($sformatf("rr%0d_res_data", i),  32'(bus.res_data),  32'(exp_id));
      if (i == 4) bus.req = 4'b0000;
      tick();
      check($sformatf("rr%0d_idle", i), 32'(bus.busy), 32'h0);
    end
    idle_inputs();

    // Requester 2 with stalls; requester 1 drives valid but is never ready
    bus.req      = 4'b0100;
    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b0010;
    bus.in_data  = 32'h0000_5500;
    tick();
    check("t3_gnt",      32'(bus.gnt),      32'h4);
    check("t3_in_ready", 32'(bus.in_ready), 32'h4);
    bus.req      = 4'b0000;  // dropping req mid-transaction must not end it
    bus.in_valid = 4'b0110;
    bus.in_data  = 32'h00FF_5500;
    tick();
    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b0110;  // last without valid: ignored
    bus.in_data  = 32'h00AA_5500;
    tick();
    check("t3_stall_res_valid", 32'(bus.res_valid), 32'h0);
    check("t3_stall_in_ready",  32'(bus.in_ready),  32'h4);
    bus.in_last = 4'b0010;
    tick();
    check("t3_stall2_busy", 32'(bus.busy), 32'h1);
    bus.in_valid = 4'b0110;
    bus.in_last  = 4'b0110;
    bus.in_data  = 32'h000F_5500;
    tick();
    check("t3_res_valid", 32'(bus.res_valid), 32'h1);
    check("t3_res_data",  32'(bus.res_data),  32'hF0);
    check("t3_res_id",    32'(bus.res_id),    32'h2);
    idle_inputs();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Result backpressure: ptr=2 so requester 0 wins next
    bus.req      = 4'b0001;
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    bus.in_data  = 32'h0000_0007;
    tick();
    check("t4_gnt", 32'(bus.gnt), 32'h1);
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold%0d_data", i),     32'(bus.res_data),  32'h07);
      check($sformatf("t4_hold%0d_id", i),       32'(bus.res_id),    32'h0);
      check($sformatf("t4_hold%0d_valid", i),    32'(bus.res_valid), 32'h1);
      check($sformatf("t4_hold%0d_busy", i),     32'(bus.busy),      32'h1);
      check($sformatf("t4_hold%0d_gnt", i),      32'(bus.gnt),       32'h0);
      check($sformatf("t4_hold%0d_in_ready", i), 32'(bus.in_ready),  32'h0);
`ifdef XOR_SCHEDULER_PARITY_EN
      check($sformatf("t4_hold%0d_parity", i),   32'(bus.res_parity), 32'h1);
`endif
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    check("t4_accept_busy",  32'(bus.busy),      32'h0);
    check("t4_accept_valid", 32'(bus.res_valid), 32'h0);
    bus.res_ready = 1'b0;

    // One-word result 03 (parity 0)
    bus.req      = 4'b0001;
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    bus.in_data  = 32'h0000_0003;
    tick();
    tick();
    check("t5_res_data", 32'(bus.res_data), 32'h03);
`ifdef XOR_SCHEDULER_PARITY_EN
    check("t5_parity", 32'(bus.res_parity), 32'h0);
`endif
    idle_inputs();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;

    // Reset mid-ACCUM after two beats
    bus.req = 4'b0001;
    tick();
    check("t6_gnt", 32'(bus.gnt), 32'h1);
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_0011;
    tick();
    bus.in_data  = 32'h0000_0022;
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    idle_inputs();
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("t6_no_res_valid", 32'(bus.res_valid), 32'h0);
    check("t6_no_busy",      32'(bus.busy),      32'h0);
    bus.req      = 4'b0001;
    bus.in_valid = 4'b0001;
    bus.in_last  = 4'b0001;
    bus.in_data  = 32'h0000_0012;
    tick();
    check("t6_new_gnt", 32'(bus.gnt), 32'h1);
    tick();
    check("t6_res_valid", 32'(bus.res_valid), 32'h1);
    check("t6_res_data",  32'(bus.res_data),  32'h12);
    check("t6_res_id",    32'(bus.res_id),    32'h0);
    idle_inputs();
    bus.res_ready = 1'b1;
    tick();
    check("t6_accept_busy", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xor_scheduler.md
XOR_SCHEDULER -- requirements
Module: xor_scheduler

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data word width in bits (legal 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester request for the shared XOR accumulator.
REQ-005 SHALL have port: in_data  input  4*WIDTH  packed words; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port: in_valid  input  4  per-requester word valid.
REQ-007 SHALL have port: in_last  input  4  per-requester final word of transaction.
REQ-008 SHALL have port: in_ready  output  4  per-requester word accept.
REQ-009 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port: res_data  output  WIDTH  XOR checksum of the completed transaction.
REQ-012 SHALL have port: res_id  output  2  index of the requester that owns res_data.
REQ-013 SHALL have port: res_valid  output  1  result valid; res_ready  input  1  result accept.

Function
REQ-014 SHALL implement exactly three states: IDLE, ACCUM, DONE.
REQ-015 IDLE: if req != 0, choose the winner round-robin, searching from (ptr+1) mod 4 upward with wrap; next cycle gnt = one-hot winner, acc = 0, state = ACCUM (req-to-gnt latency exactly 1 cycle).
REQ-016 IDLE with req == 0: no state change, gnt = 0.
REQ-017 ACCUM: in_ready = gnt (combinational from registered gnt); in_ready of non-granted requesters SHALL be 0 and their in_data/in_valid/in_last ignored.
REQ-018 Beat = in_valid[g] & in_ready[g]; on each beat acc <= acc ^ in_data[g]; in_valid low stalls with no acc change.
REQ-019 Beat with in_last[g] high: res_data <= acc ^ in_data[g], res_id <= g, res_valid <= 1, gnt <= 0, ptr <= g, state = DONE; in_last without in_valid SHALL have no effect.
REQ-020 Deassertion of req[g] during ACCUM SHALL be ignored; only an in_last beat ends a transaction.
REQ-021 DONE: res_data/res_id/res_valid held stable until res_valid & res_ready; that cycle state = IDLE, res_valid <= 0; in_ready = 0 throughout DONE.
REQ-022 A one-word transaction (in_last on first beat) SHALL yield res_data = that word.
REQ-023 Minimum transaction turnaround: grant cycle + N beats + 1 result cycle + 1 arbitration cycle; no back-to-back grant bypassing IDLE.

Reset
REQ-024 rst_n low SHALL asynchronously force state = IDLE, ptr = 3 (requester 0 wins first), acc = 0, gnt = 0, in_ready = 0, busy = 0, res_data = 0, res_id = 0, res_valid = 0.
REQ-025 Reset mid-ACCUM or mid-DONE SHALL abort the transaction; no result emitted after release.
REQ-026 Release of rst_n SHALL take effect at the first rising clk edge with rst_n high.

Configuration
REQ-027 Macro XOR_SCHEDULER_PARITY_EN defined: add output res_parity (1 bit) = reduction XOR of res_data, registered with res_data, reset 0, valid qualified by res_valid.
REQ-028 Macro XOR_SCHEDULER_PARITY_EN undefined: port res_parity and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then req=4'b0001, requester 0 sends 8'hA5, 8'h3C(last) -> gnt=0001 one cycle after req, res_data=8'h99, res_id=0, res_valid until res_ready.
REQ-030 req=4'b1111 held, each sends one word 8'h0i(last) -> grants in order 0,1,2,3,0; res_id sequence 0,1,2,3,0.
REQ-031 Requester 2 granted, in_valid toggles 1,0,0,1(last) with 8'hFF,—,—,8'h0F; requester 1 drives valid throughout -> in_ready[1]=0 always, res_data=8'hF0, res_id=2.
REQ-032 res_ready held low 5 cycles after completion -> res_data/res_id stable, busy=1, gnt=0, in_ready=0; accepted on 6th cycle, busy=0 next cycle.
REQ-033 rst_n pulsed low mid-ACCUM after two beats -> all outputs 0 immediately; after release new requester-0 transaction 8'h12(last) gives res_data=8'h12.
REQ-034 With XOR_SCHEDULER_PARITY_EN, result 8'h07 -> res_parity=1; result 8'h03 -> res_parity=0.
